dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the 5-stage RV32 core; generalises the plain data RAM.

---
 rtl/dmem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: valid/ready request handshake, optional wait states,
// B/H/W loads and stores on an internal word array with misaligned/illegal-op errors.
module dmem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_w,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam int unsigned LaneAw  = IdxW + 2;
    localparam logic [3:0]  CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] OpB  = 3'b000;
    localparam logic [2:0] OpH  = 3'b001;
    localparam logic [2:0] OpW  = 3'b010;
    localparam logic [2:0] OpBu = 3'b100;
    localparam logic [2:0] OpHu = 3'b101;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              w_q, w_d;
    logic [2:0]        op_q, op_d;
    logic [LaneAw-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept, commit, mem_we, in_wait;
    logic              acc_w, acc_err;
    logic [2:0]        acc_op;
    logic [LaneAw-1:0] acc_addr;
    logic [IdxW-1:0]   acc_idx;
    logic [31:0]       acc_wdata, rword, load_val, st_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [3:0]        be;

    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:LaneAw];

    assign rsp_valid = (state_q == StResp);
    assign req_ready = (state_q == StIdle) | rsp_valid;
    assign busy      = (state_q != StIdle) & ~rsp_valid;
    assign rdata     = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;
    assign accept    = req_valid & req_ready;

    // The array is accessed on the edge that enters StResp: with no wait states that is the
    // accept edge itself, so the live request is used; otherwise the latched copy.
    always_comb begin
        in_wait   = (state_q == StWait);
        acc_w     = in_wait ? w_q : req_w;
        acc_op    = in_wait ? op_q : mem_op;
        acc_addr  = in_wait ? addr_q : addr[LaneAw-1:0];
        acc_wdata = in_wait ? wdata_q : wdata;
        acc_idx   = acc_addr[LaneAw-1:2];
        commit    = (WAIT_CYCLES == 0) ? accept : (in_wait && (cnt_q == 4'd0));

        acc_err = 1'b0;
        case (acc_op)
            OpB:        acc_err = 1'b0;
            OpH:        acc_err = acc_addr[0];
            OpW:        acc_err = (acc_addr[1:0] != 2'b00);
            OpBu:       acc_err = acc_w;
            OpHu:       acc_err = acc_w | acc_addr[0];
            default:    acc_err = 1'b1;
        endcase

        rword  = mem[acc_idx];
        lane_b = rword[{acc_addr[1:0], 3'b000} +: 8];
        lane_h = acc_addr[1] ? rword[31:16] : rword[15:0];
        case (acc_op)
            OpB:     load_val = {{24{lane_b[7]}}, lane_b};
            OpH:     load_val = {{16{lane_h[15]}}, lane_h};
            OpW:     load_val = rword;
            OpBu:    load_val = {24'd0, lane_b};
            OpHu:    load_val = {16'd0, lane_h};
            default: load_val = 32'd0;
        endcase

        be      = 4'b0000;
        st_data = acc_wdata;
        case (acc_op[1:0])
            2'b00: begin
                be      = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be      = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        mem_we = commit & acc_w & ~acc_err & ~rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    w_d     = req_w;
                    op_d    = mem_op;
                    addr_d  = addr[LaneAw-1:0];
                    wdata_d = wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StResp;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err | acc_w) ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            w_q     <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with no wait states and one with three, driven from a
// request table plus hand sequences; responses are checked against a scoreboard queue.
module tb_dmem_ctrl;
    localparam int unsigned Depth = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, req_valid, req_ready, req_w, rsp_valid, rsp_err, busy;
    logic [2:0]  mem_op [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_w(req_w[0]), .mem_op(mem_op[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(Depth), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_w(req_w[1]), .mem_op(mem_op[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    typedef struct {
        int          sel;
        logic        w;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          id;
    } exp_t;

    vec_t tbl[$];
    exp_t q0[$];
    exp_t q1[$];
    int checks  = 0;
    int errors  = 0;
    int next_id = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic add(input int s, input logic w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = s; v.w = w; v.op = op; v.a = a; v.wd = wd; v.er = er; v.ee = ee;
        tbl.push_back(v);
    endtask

    // Advance to the next falling edge and score whatever both DUTs present there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            if (rsp_valid[s]) begin
                if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp%0d: got rsp_valid=1, expected 0 (cycle %0d)",
                             s, cyc);
                end else begin
                    if (s == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("rsp%0d_rdata id%0d", s, e.id), rdata[s], e.rd);
                    check($sformatf("rsp%0d_err id%0d", s, e.id), {31'd0, rsp_err[s]},
                          {31'd0, e.err});
                    check($sformatf("rsp%0d_cycle id%0d", s, e.id), 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check($sformatf("idle%0d_rdata", s), rdata[s], 32'd0);
                check($sformatf("idle%0d_err", s), {31'd0, rsp_err[s]}, 32'd0);
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic do_req(input int s, input logic w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input bit track);
        int   guard = 0;
        exp_t e;
        req_valid[s] = 1'b1;
        req_w[s]     = w;
        mem_op[s]    = op;
        addr[s]      = a;
        wdata[s]     = wd;
        while (!req_ready[s] && guard < 40) begin
            tick();
            guard++;
        end
        if (!req_ready[s]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: got req_ready=0, expected 1 (cycle %0d)", s, cyc);
            req_valid[s] = 1'b0;
            return;
        end
        if (track) begin
            e.rd  = er;
            e.err = ee;
            e.cyc = cyc + 1 + ((s == 1) ? 3 : 0);
            e.id  = next_id;
            next_id++;
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        tick();
        req_valid[s] = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        rst       = 2'b11;
        req_valid = 2'b00;
        req_w     = 2'b00;
        for (int s = 0; s < 2; s++) begin
            mem_op[s] = 3'd0;
            addr[s]   = 32'd0;
            wdata[s]  = 32'd0;
        end

        // No wait states: data path, lanes, extension, errors, aliasing.
        add(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        add(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        add(0, 1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0);
        add(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        add(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        add(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        add(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
        add(0, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        add(0, 1'b1, 3'b010, 32'h14, 32'h11223344, 32'h0, 1'b0);
        add(0, 1'b1, 3'b001, 32'h16, 32'hFFFF7F01, 32'h0, 1'b0);
        add(0, 1'b0, 3'b010, 32'h14, 32'h0, 32'h7F013344, 1'b0);
        add(0, 1'b0, 3'b000, 32'h15, 32'h0, 32'h00000033, 1'b0);
        add(0, 1'b0, 3'b000, 32'h17, 32'h0, 32'h0000007F, 1'b0);
        add(0, 1'b0, 3'b001, 32'h16, 32'h0, 32'h00007F01, 1'b0);
        add(0, 1'b0, 3'b100, 32'h14, 32'h0, 32'h00000044, 1'b0);
        add(0, 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
        add(0, 1'b1, 3'b001, 32'h13, 32'hAAAAAAAA, 32'h0, 1'b1);
        add(0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        add(0, 1'b1, 3'b100, 32'h10, 32'h55555555, 32'h0, 1'b1);
        add(0, 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1);
        add(0, 1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1);
        add(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        add(0, 1'b0, 3'b010, 32'h14, 32'h0, 32'h7F013344, 1'b0);
        add(0, 1'b0, 3'b010, Depth * 4 + 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        // Three wait states: set up words for the hand sequences.
        add(1, 1'b1, 3'b010, 32'h10, 32'h80ADBEEF, 32'h0, 1'b0);
        add(1, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        add(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        repeat (3) tick();
        rst = 2'b00;
        tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset%0d_ready", s), {31'd0, req_ready[s]}, 32'd1);
            check($sformatf("reset%0d_rsp_valid", s), {31'd0, rsp_valid[s]}, 32'd0);
            check($sformatf("reset%0d_busy", s), {31'd0, busy[s]}, 32'd0);
        end

        foreach (tbl[i]) begin
            do_req(tbl[i].sel, tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].ee,
                   1'b1);
        end
        drain();

        // LH during wait states: stalled for three cycles, then the response.
        do_req(1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("wait_busy T+%0d", k), {31'd0, busy[1]}, 32'd1);
            check($sformatf("wait_ready T+%0d", k), {31'd0, req_ready[1]}, 32'd0);
            tick();
        end
        check("resp_busy", {31'd0, busy[1]}, 32'd0);
        check("resp_ready", {31'd0, req_ready[1]}, 32'd1);
        drain();

        // Reset in the first wait cycle of a store.
        do_req(1, 1'b1, 3'b010, 32'h0, 32'h00000001, 32'h0, 1'b0, 1'b0);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check("rst_wait_ready", {31'd0, req_ready[1]}, 32'd1);
        check("rst_wait_busy", {31'd0, busy[1]}, 32'd0);
        check("rst_wait_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        repeat (4) tick();

        // Reset on the very edge that would commit the store.
        do_req(1, 1'b1, 3'b010, 32'h0, 32'h00000002, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check("rst_resp_ready", {31'd0, req_ready[1]}, 32'd1);
        check("rst_resp_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        repeat (4) tick();

        do_req(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        do_req(1, 1'b0, 3'b010, Depth * 4, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
